// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: opcodes, FSM states,
// datapath select codes and the per-state control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StJalrPc   = 4'd12
    } state_t;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluSub    = 2'b01;
    localparam logic [1:0] AluRType  = 2'b10;
    localparam logic [1:0] AluIType  = 2'b11;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResData   = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [1:0] ImmI      = 2'b00;
    localparam logic [1:0] ImmS      = 2'b01;
    localparam logic [1:0] ImmB      = 2'b10;
    localparam logic [1:0] ImmJ      = 2'b11;

    // Raw per-state controls; *_on_ready and pc_write_zero are qualified in the top.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic       pc_write;
        logic       pc_write_zero;
        logic       fetch_on_ready;
        logic       retire;
        logic       retire_on_ready;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OpStore:  sel = ImmS;
            OpBranch: sel = ImmB;
            OpJal:    sel = ImmJ;
            default:  sel = ImmI;
        endcase
        return sel;
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal, OpJalr: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from FSM state to the raw datapath control word.
module mc_ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.mem_req        = 1'b1;
                ctrl_o.fetch_on_ready = 1'b1;
                ctrl_o.alu_src_a      = SrcAPc;
                ctrl_o.alu_src_b      = SrcBFour;
                ctrl_o.alu_op         = AluAdd;
                ctrl_o.result_src     = ResAlu;
            end
            StDecode: begin
                ctrl_o.alu_src_a = SrcAOldPc;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAdd;
            end
            StMemAdr, StJalr: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAdd;
            end
            StMemRead: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.adr_src = 1'b1;
            end
            StMemWb: begin
                ctrl_o.result_src = ResData;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.retire     = 1'b1;
            end
            StMemWrite: begin
                ctrl_o.mem_req         = 1'b1;
                ctrl_o.mem_write       = 1'b1;
                ctrl_o.adr_src         = 1'b1;
                ctrl_o.retire_on_ready = 1'b1;
            end
            StExecR: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBRs2;
                ctrl_o.alu_op    = AluRType;
            end
            StExecI: begin
                ctrl_o.alu_src_a = SrcARs1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluIType;
            end
            StAluWb: begin
                ctrl_o.result_src = ResAluOut;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.retire     = 1'b1;
            end
            StBeq: begin
                ctrl_o.alu_src_a     = SrcARs1;
                ctrl_o.alu_src_b     = SrcBRs2;
                ctrl_o.alu_op        = AluSub;
                ctrl_o.result_src    = ResAluOut;
                ctrl_o.pc_write_zero = 1'b1;
                ctrl_o.retire        = 1'b1;
            end
            StJal, StJalrPc: begin
                // PC takes the target in ALUOut while the ALU forms the link value.
                ctrl_o.alu_src_a  = SrcAOldPc;
                ctrl_o.alu_src_b  = SrcBFour;
                ctrl_o.alu_op     = AluAdd;
                ctrl_o.result_src = ResAluOut;
                ctrl_o.pc_write   = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core: state register, next-state
// logic, memory handshake qualification and the retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [6:0]           opcode_i,
    input  logic                 zero_i,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic                 adr_src_o,
    output logic                 ir_write_o,
    output logic                 pc_write_o,
    output logic                 reg_write_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           alu_op_o,
    output logic [1:0]           imm_src_o,
    output logic [1:0]           result_src_o,
    output logic                 illegal_o,
    output logic                 retire_o,
    output logic [INSTRET_W-1:0] instret_o,
    output logic [3:0]           state_dbg_o
);

    state_t               state_q, state_d;
    ctrl_t                ctrl;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    mc_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (opcode_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (opcode_i == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready_i) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready_i) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StJalr:     state_d = StJalrPc;
            StJalrPc:   state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Reset dominates every input, so a pending access is dropped without side effects.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        imm_src_o    = 2'b00;
        result_src_o = 2'b00;
        illegal_o    = 1'b0;
        retire_o     = 1'b0;
        if (!rst_i) begin
            mem_req_o    = ctrl.mem_req;
            mem_write_o  = ctrl.mem_write;
            adr_src_o    = ctrl.adr_src;
            ir_write_o   = ctrl.fetch_on_ready & mem_ready_i;
            pc_write_o   = ctrl.pc_write | (ctrl.fetch_on_ready & mem_ready_i)
                         | (ctrl.pc_write_zero & zero_i);
            reg_write_o  = ctrl.reg_write;
            alu_src_a_o  = ctrl.alu_src_a;
            alu_src_b_o  = ctrl.alu_src_b;
            alu_op_o     = ctrl.alu_op;
            imm_src_o    = imm_sel(opcode_i);
            result_src_o = ctrl.result_src;
            illegal_o    = (state_q == StDecode) && !op_legal(opcode_i);
            retire_o     = ctrl.retire | (ctrl.retire_on_ready & mem_ready_i);
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (retire_o) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o   = instret_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, imm_src, result_src;
    logic        illegal, retire;
    logic [31:0] instret;
    logic [3:0]  state_dbg;

    // Narrow-counter twin sharing all inputs, used to exercise the wrap from all-ones.
    logic        w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
    logic [1:0]  w_alu_src_a, w_alu_src_b, w_alu_op, w_imm_src, w_result_src;
    logic        w_illegal, w_retire;
    logic [1:0]  w_instret;
    logic [3:0]  w_state_dbg;

    always #5 clk = ~clk;

    multicycle_controller #(.INSTRET_W(32)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .mem_req_o    (mem_req),
        .mem_write_o  (mem_write),
        .adr_src_o    (adr_src),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .imm_src_o    (imm_src),
        .result_src_o (result_src),
        .illegal_o    (illegal),
        .retire_o     (retire),
        .instret_o    (instret),
        .state_dbg_o  (state_dbg)
    );

    multicycle_controller #(.INSTRET_W(2)) u_dut_w (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .mem_req_o    (w_mem_req),
        .mem_write_o  (w_mem_write),
        .adr_src_o    (w_adr_src),
        .ir_write_o   (w_ir_write),
        .pc_write_o   (w_pc_write),
        .reg_write_o  (w_reg_write),
        .alu_src_a_o  (w_alu_src_a),
        .alu_src_b_o  (w_alu_src_b),
        .alu_op_o     (w_alu_op),
        .imm_src_o    (w_imm_src),
        .result_src_o (w_result_src),
        .illegal_o    (w_illegal),
        .retire_o     (w_retire),
        .instret_o    (w_instret),
        .state_dbg_o  (w_state_dbg)
    );

    typedef struct {
        logic [3:0]  st;
        logic [7:0]  strb;  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal, retire}
        logic [9:0]  sel;   // {alu_src_a, alu_src_b, alu_op, imm_src, result_src}
        int unsigned ir;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every presented cycle of controls is matched against the next queued vector.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", {28'd0, state_dbg}, {28'd0, e.st});
            chk("strobes", {24'd0, mem_req, mem_write, adr_src, ir_write, pc_write,
                            reg_write, illegal, retire}, {24'd0, e.strb});
            chk("selects", {22'd0, alu_src_a, alu_src_b, alu_op, imm_src, result_src},
                {22'd0, e.sel});
            chk("instret", instret, e.ir);
            chk("instret_w2", {30'd0, w_instret}, e.ir % 4);
            cyc++;
        end
    end

    task automatic step(input logic r, input logic rdy, input logic z, input logic [3:0] st,
                        input logic [7:0] strb, input logic [9:0] sel, input int unsigned ir);
        exp_t e;
        rst       = r;
        mem_ready = rdy;
        zero      = z;
        e         = '{st, strb, sel, ir};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = OpIType;
        @(posedge clk);
        #1;
        // Held in reset: everything quiet, counter clear.
        step(1, 1, 0, StFetch,  8'b0000_0000, 10'b00_00_00_00_00, 0);

        // ADDI, no wait states.
        step(0, 1, 0, StFetch,  8'b1001_1000, 10'b00_10_00_00_10, 0);
        step(0, 1, 0, StDecode, 8'b0000_0000, 10'b01_01_00_00_00, 0);
        step(0, 1, 0, StExecI,  8'b0000_0000, 10'b10_01_11_00_00, 0);
        step(0, 1, 0, StAluWb,  8'b0000_0101, 10'b00_00_00_00_00, 0);

        // LW with three wait cycles in MEMREAD.
        opcode = OpLoad;
        step(0, 1, 0, StFetch,   8'b1001_1000, 10'b00_10_00_00_10, 1);
        step(0, 1, 0, StDecode,  8'b0000_0000, 10'b01_01_00_00_00, 1);
        step(0, 1, 0, StMemAdr,  8'b0000_0000, 10'b10_01_00_00_00, 1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, StMemRead, 8'b1010_0000, 10'b00_00_00_00_00, 1);
        step(0, 1, 0, StMemRead, 8'b1010_0000, 10'b00_00_00_00_00, 1);
        step(0, 1, 0, StMemWb,   8'b0000_0101, 10'b00_00_00_00_01, 1);

        // BEQ taken, then not taken.
        opcode = OpBranch;
        step(0, 1, 1, StFetch,  8'b1001_1000, 10'b00_10_00_10_10, 2);
        step(0, 1, 1, StDecode, 8'b0000_0000, 10'b01_01_00_10_00, 2);
        step(0, 1, 1, StBeq,    8'b0000_1001, 10'b10_00_01_10_00, 2);
        step(0, 1, 0, StFetch,  8'b1001_1000, 10'b00_10_00_10_10, 3);
        step(0, 1, 0, StDecode, 8'b0000_0000, 10'b01_01_00_10_00, 3);
        step(0, 1, 0, StBeq,    8'b0000_0001, 10'b10_00_01_10_00, 3);

        // JALR; the 2-bit twin has just wrapped from 3 to 0.
        opcode = OpJalr;
        step(0, 1, 0, StFetch,  8'b1001_1000, 10'b00_10_00_00_10, 4);
        step(0, 1, 0, StDecode, 8'b0000_0000, 10'b01_01_00_00_00, 4);
        step(0, 1, 0, StJalr,   8'b0000_0000, 10'b10_01_00_00_00, 4);
        step(0, 1, 0, StJalrPc, 8'b0000_1000, 10'b01_10_00_00_00, 4);
        step(0, 1, 0, StAluWb,  8'b0000_0101, 10'b00_00_00_00_00, 4);

        // JAL with one fetch wait cycle.
        opcode = OpJal;
        step(0, 0, 0, StFetch,  8'b1000_0000, 10'b00_10_00_11_10, 5);
        step(0, 1, 0, StFetch,  8'b1001_1000, 10'b00_10_00_11_10, 5);
        step(0, 1, 0, StDecode, 8'b0000_0000, 10'b01_01_00_11_00, 5);
        step(0, 1, 0, StJal,    8'b0000_1000, 10'b01_10_00_11_00, 5);
        step(0, 1, 0, StAluWb,  8'b0000_0101, 10'b00_00_00_11_00, 5);

        // Unsupported opcode (LUI): illegal pulse, no retire.
        opcode = 7'b0110111;
        step(0, 1, 0, StFetch,  8'b1001_1000, 10'b00_10_00_00_10, 6);
        step(0, 1, 0, StDecode, 8'b0000_0010, 10'b01_01_00_00_00, 6);

        // R-type.
        opcode = OpRType;
        step(0, 1, 0, StFetch,  8'b1001_1000, 10'b00_10_00_00_10, 6);
        step(0, 1, 0, StDecode, 8'b0000_0000, 10'b01_01_00_00_00, 6);
        step(0, 1, 0, StExecR,  8'b0000_0000, 10'b10_00_10_00_00, 6);
        step(0, 1, 0, StAluWb,  8'b0000_0101, 10'b00_00_00_00_00, 6);

        // SW abandoned by reset asserted together with mem_ready.
        opcode = OpStore;
        step(0, 1, 0, StFetch,    8'b1001_1000, 10'b00_10_00_01_10, 7);
        step(0, 1, 0, StDecode,   8'b0000_0000, 10'b01_01_00_01_00, 7);
        step(0, 1, 0, StMemAdr,   8'b0000_0000, 10'b10_01_00_01_00, 7);
        step(0, 0, 0, StMemWrite, 8'b1110_0000, 10'b00_00_00_01_00, 7);
        step(1, 1, 0, StMemWrite, 8'b0000_0000, 10'b00_00_00_00_00, 7);
        step(0, 0, 0, StFetch,    8'b1000_0000, 10'b00_10_00_01_10, 0);

        // Complete SW after reset.
        step(0, 1, 0, StFetch,    8'b1001_1000, 10'b00_10_00_01_10, 0);
        step(0, 1, 0, StDecode,   8'b0000_0000, 10'b01_01_00_01_00, 0);
        step(0, 1, 0, StMemAdr,   8'b0000_0000, 10'b10_01_00_01_00, 0);
        step(0, 1, 0, StMemWrite, 8'b1110_0001, 10'b00_00_00_01_00, 0);
        step(0, 0, 0, StFetch,    8'b1000_0000, 10'b00_10_00_01_10, 1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked vectors, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main sequencing FSM for the multi-cycle RV32I core: a single shared ALU, a unified instruction/data memory port, and IR, OldPC, ALUOut and Data registers.
- Decodes the opcode latched in IR and steps the datapath through fetch/decode/execute/writeback states, one micro-step per clock.
- Owns the memory request handshake, branch resolution (pc_write), illegal-opcode detection and the retired-instruction counter.
- Sits beside the existing combinational ALU-decode logic, which consumes alu_op.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter (wraps modulo 2^INSTRET_W).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]
- zero  in  1  ALU zero flag (BEQ compare)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a store
- adr_src  out  1  0=PC, 1=ALUOut as memory address
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  load PC from result bus
- reg_write  out  1  register-file write
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=ImmExt, 10=constant 4
- alu_op  out  2  00=add, 01=sub/branch, 10=R-type, 11=I-type
- imm_src  out  2  00=I, 01=S, 10=B, 11=J (combinational from opcode)
- result_src  out  2  00=ALUOut, 01=Data, 10=ALU result
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  INSTRET_W  retired-instruction count
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (synchronous, active-high):
  - State goes to FETCH; instret clears to 0.
  - During any cycle with rst=1, all strobes (mem_req, mem_write, ir_write, pc_write, reg_write, illegal, retire) are forced to 0; selects are 00.
  - rst beats every other input, including mem_ready. Reset mid-access abandons the access with no writes.
- Outputs are Moore, decoded from state. Exceptions:
  - imm_src decodes from opcode.
  - pc_write, ir_write, retire are qualified as stated below.
- FETCH:
  - Drives mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - Holds while mem_ready=0.
  - On the cycle mem_ready=1: ir_write=1 and pc_write=1 (PC <= PC+4), then go to DECODE.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00; ALUOut <= OldPC+imm (branch/JAL target).
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 1100111 -> JALR.
  - Any other opcode: illegal=1 for this cycle, next state FETCH, no retire.
- MEMADR:
  - alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD:
  - mem_req=1, adr_src=1; holds until mem_ready, then MEMWB.
- MEMWB:
  - result_src=01, reg_write=1, retire=1, then FETCH.
- MEMWRITE:
  - mem_req=1, mem_write=1, adr_src=1; holds until mem_ready.
  - On the ready cycle: retire=1, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=11, then ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1, then FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero; retire=1; then FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 (PC <= target, ALUOut <= OldPC+4).
  - Then ALUWB.
- JALR:
  - JALR state: alu_src_a=10, alu_src_b=01, alu_op=00 (ALUOut <= rs1+imm), then JALR_PC.
  - JALR_PC: same controls and next state as JAL.
- Cycle counts with mem_ready tied high:
  - R/I: 4. Load: 5. Store: 4. BEQ: 3. JAL: 4. JALR: 5. Illegal: 2.
  - Each extra mem_ready=0 cycle adds one cycle.
- mem_req never deasserts mid-request: it stays high from its first cycle until the mem_ready cycle. The address select is stable throughout the request.
- instret increments on every retire cycle and wraps from all-ones to 0.
- Illegal state encodings (unreachable) recover to FETCH on the next clock with all strobes low.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants;
  - the state enum (4-bit);
  - localparams for the alu_src_a, alu_src_b, result_src, imm_src and alu_op encodings.
- One natural sub-module: mc_ctrl_decode, a combinational state -> control-word map.
- The top module keeps the state register, next-state logic, handshake qualification and instret.

Test Plan:
- Reset mid-MEMWRITE: rst=1 with mem_ready=1 in the same cycle -> mem_write=0, no retire, state=FETCH, instret=0.
- ADDI (opcode 0010011), mem_ready=1 -> states FETCH, DECODE, EXECI, ALUWB; alu_op=11 in EXECI; one reg_write; retire on cycle 4; instret=1.
- LW with mem_ready low 3 cycles in MEMREAD -> mem_req high for exactly 4 consecutive cycles with adr_src=1; MEMWB result_src=01; total 8 cycles.
- BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 in BEQ state for the first only; both retire; 3 cycles each.
- JALR -> DECODE, JALR, JALR_PC, ALUWB; pc_write in FETCH and JALR_PC only; reg_write with result_src=00 in ALUWB.
- Opcode 0110111 (unsupported) -> illegal pulses one cycle in DECODE, return to FETCH, instret unchanged. Separately, preload instret to all-ones and retire once -> instret=0.
